// File: rtl/inst_dispatch_if.sv
// inst_dispatch_if -- instruction-memory and execution-unit bus of the dispatcher.
//   imem_rd/imem_addr -> fetch request; imem_rvalid/imem_rdata <- fetch return
//   cmd_inst          -> current instruction, broadcast to every unit for decode
//   ldst_valid/ldst_ready/ldst_done, mv_valid/mv_ready/mv_done -> unit handshakes
//   eu_valid (one-hot) / eu_ready / eu_busy -> per exec unit handshake and status
// master: the dispatcher; slave: memory and units.
interface inst_dispatch_if #(
  parameter int unsigned NUM_EU      = 8,
  parameter int unsigned IMEM_ADDR_W = 12
);
  logic                   imem_rd;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic                   imem_rvalid;
  logic [31:0]            imem_rdata;
  logic [31:0]            cmd_inst;
  logic                   ldst_valid;
  logic                   ldst_ready;
  logic                   ldst_done;
  logic                   mv_valid;
  logic                   mv_ready;
  logic                   mv_done;
  logic [NUM_EU-1:0]      eu_valid;
  logic [NUM_EU-1:0]      eu_ready;
  logic [NUM_EU-1:0]      eu_busy;

  modport master (
    output imem_rd, imem_addr, cmd_inst, ldst_valid, mv_valid, eu_valid,
    input  imem_rvalid, imem_rdata, ldst_ready, ldst_done, mv_ready, mv_done,
           eu_ready, eu_busy
  );

  modport slave (
    input  imem_rd, imem_addr, cmd_inst, ldst_valid, mv_valid, eu_valid,
    output imem_rvalid, imem_rdata, ldst_ready, ldst_done, mv_ready, mv_done,
           eu_ready, eu_busy
  );
endinterface

// File: rtl/inst_dispatch.sv
// inst_dispatch -- sequential instruction dispatcher.
// Fetches prog_len instructions starting at prog_base, routes each to the
// load/store unit, the move unit or one of NUM_EU exec units, and pulses done
// once every exec unit has gone idle.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, abort      launch pulse (IDLE/ERROR only); synchronous kill
//   prog_base/len     first instruction address; instruction count
//   busy, done, err   running; one-cycle completion; sticky illegal unit
//   perf_cycles/stalls busy-cycle and issue-stall counters
//   bus (master)      instruction memory and unit handshakes
// Build option: define INST_DISPATCH_PERF_EN to enable the perf counters;
// otherwise both perf outputs are tied to zero.
// The interface instance must use the same NUM_EU / IMEM_ADDR_W as this module.
module inst_dispatch #(
  parameter int unsigned NUM_EU      = 8,
  parameter int unsigned IMEM_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [IMEM_ADDR_W-1:0] prog_base,
  input  logic [15:0]            prog_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            perf_cycles,
  output logic [31:0]            perf_stalls,
  inst_dispatch_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE, IFETCH, IWAIT, ISSUE, WAIT_DONE, DRAIN, ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]            remain_q, remain_d;
  logic [31:0]            cmd_inst_q, cmd_inst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   imem_rd_q, imem_rd_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic                   ldst_valid_q, ldst_valid_d;
  logic                   mv_valid_q, mv_valid_d;
  logic [NUM_EU-1:0]      eu_valid_q, eu_valid_d;

  logic [1:0]        op;
  logic [4:0]        unit;
  logic              is_ldst, is_mv, is_eu, unit_ok;
  logic [NUM_EU-1:0] unit_oh;
  logic              sel_busy;
  logic              ldst_hs, mv_hs, eu_hs;
  logic              accept_start, advance;

  // Decode of the registered instruction
  always_comb begin
    op       = cmd_inst_q[31:30];
    unit     = cmd_inst_q[28:24];
    is_ldst  = ~op[1];
    is_mv    = (op == 2'b10);
    is_eu    = (op == 2'b11);
    unit_ok  = (32'(unit) < NUM_EU);
    unit_oh  = '0;
    sel_busy = 1'b0;
    for (int unsigned i = 0; i < NUM_EU; i++) begin
      unit_oh[i] = (32'(unit) == i);
      sel_busy   = sel_busy | (unit_oh[i] & bus.eu_busy[i]);
    end
    ldst_hs      = ldst_valid_q & bus.ldst_ready;
    mv_hs        = mv_valid_q & bus.mv_ready;
    eu_hs        = |(eu_valid_q & bus.eu_ready);
    accept_start = start & ~abort & ((state_q == IDLE) | (state_q == ERROR));
  end

  // Next state and datapath
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    remain_d   = remain_q;
    cmd_inst_d = cmd_inst_q;
    err_d      = err_q;
    done_d     = 1'b0;
    advance    = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, ERROR: begin
          if (accept_start) begin
            pc_d     = prog_base;
            remain_d = prog_len;
            err_d    = 1'b0;
            state_d  = (prog_len == 16'd0) ? DRAIN : IFETCH;
          end
        end
        IFETCH: state_d = IWAIT;
        IWAIT: begin
          if (bus.imem_rvalid) begin
            cmd_inst_d = bus.imem_rdata;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          if (is_eu && !unit_ok) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else if (ldst_hs || mv_hs) begin
            state_d = WAIT_DONE;
          end else if (eu_hs) begin
            advance = 1'b1;
          end
        end
        WAIT_DONE: begin
          if ((is_ldst && bus.ldst_done) || (is_mv && bus.mv_done)) advance = 1'b1;
        end
        DRAIN: begin
          if (bus.eu_busy == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (advance) begin
        pc_d     = pc_q + IMEM_ADDR_W'(1);
        remain_d = remain_q - 16'd1;
        state_d  = (remain_q > 16'd1) ? IFETCH : DRAIN;
      end
    end
  end

  // Registered outputs are derived from the next state so they line up with
  // the state they belong to. The first ISSUE cycle is a decode cycle with no
  // valid; afterwards a valid, once raised, is held until its handshake.
  always_comb begin
    busy_d       = (state_d != IDLE) && (state_d != ERROR);
    imem_rd_d    = (state_d == IFETCH);
    imem_addr_d  = imem_rd_d ? pc_d : imem_addr_q;
    ldst_valid_d = 1'b0;
    mv_valid_d   = 1'b0;
    eu_valid_d   = '0;
    if ((state_d == ISSUE) && (state_q == ISSUE)) begin
      ldst_valid_d = is_ldst;
      mv_valid_d   = is_mv;
      if (is_eu) eu_valid_d = eu_valid_q | (unit_oh & {NUM_EU{~sel_busy}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      remain_q     <= '0;
      cmd_inst_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      imem_rd_q    <= 1'b0;
      imem_addr_q  <= '0;
      ldst_valid_q <= 1'b0;
      mv_valid_q   <= 1'b0;
      eu_valid_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      remain_q     <= remain_d;
      cmd_inst_q   <= cmd_inst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      imem_rd_q    <= imem_rd_d;
      imem_addr_q  <= imem_addr_d;
      ldst_valid_q <= ldst_valid_d;
      mv_valid_q   <= mv_valid_d;
      eu_valid_q   <= eu_valid_d;
    end
  end

`ifdef INST_DISPATCH_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic        sel_ready, stall;

  // A stall is an issue cycle either blocked by the target unit being busy
  // before its valid went up, or with a valid up and no ready.
  always_comb begin
    sel_ready = |(unit_oh & bus.eu_ready);
    stall = (state_q == ISSUE) &&
            ((is_eu && unit_ok && (eu_valid_q == '0) && sel_busy) ||
             (ldst_valid_q && !bus.ldst_ready) ||
             (mv_valid_q && !bus.mv_ready) ||
             ((eu_valid_q != '0) && !sel_ready));
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
    if (stall && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
    if (accept_start) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign bus.imem_rd    = imem_rd_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.cmd_inst   = cmd_inst_q;
  assign bus.ldst_valid = ldst_valid_q;
  assign bus.mv_valid   = mv_valid_q;
  assign bus.eu_valid   = eu_valid_q;

endmodule

// File: tb/tb_inst_dispatch.sv
module tb_inst_dispatch;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [11:0] prog_base;
  logic [15:0] prog_len;
  logic        busy, done, err;
  logic [31:0] perf_cycles, perf_stalls;

  int checks = 0;
  int errors = 0;

  inst_dispatch_if #(.NUM_EU(8), .IMEM_ADDR_W(12)) bif ();

  inst_dispatch #(.NUM_EU(8), .IMEM_ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prog_base(prog_base), .prog_len(prog_len),
    .busy(busy), .done(done), .err(err),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
    .bus(bif)
  );

  always #5 clk = ~clk;

  // Memory and unit responder; sampled at negedge, away from the active edge.
  logic [31:0] mem [0:4095];
  int          mem_lat  = 1;
  int          done_dly = 4;
  int          mem_cd = 0, ldst_cd = 0, mv_cd = 0;
  logic [11:0] mem_addr = '0;
  logic [11:0] addr_log[$];
  int          hs_log[$];
  int          done_cnt = 0, rd_cnt = 0, valid_cnt = 0;

  initial begin
    bif.imem_rvalid = 1'b0; bif.imem_rdata = '0;
    bif.ldst_done = 1'b0;   bif.mv_done = 1'b0;
    forever begin
      @(negedge clk);
      bif.imem_rvalid = 1'b0; bif.ldst_done = 1'b0; bif.mv_done = 1'b0;
      if (mem_cd > 0) begin
        mem_cd--;
        if (mem_cd == 0) begin bif.imem_rvalid = 1'b1; bif.imem_rdata = mem[mem_addr]; end
      end
      if (ldst_cd > 0) begin ldst_cd--; if (ldst_cd == 0) bif.ldst_done = 1'b1; end
      if (mv_cd > 0) begin mv_cd--; if (mv_cd == 0) bif.mv_done = 1'b1; end
      if (bif.imem_rd) begin
        mem_cd = mem_lat; mem_addr = bif.imem_addr;
        addr_log.push_back(bif.imem_addr); rd_cnt++;
      end
      if (bif.ldst_valid && bif.ldst_ready) begin hs_log.push_back(0); ldst_cd = done_dly; end
      if (bif.mv_valid && bif.mv_ready) begin hs_log.push_back(1); mv_cd = done_dly; end
      for (int i = 0; i < 8; i++) if (bif.eu_valid[i] && bif.eu_ready[i]) hs_log.push_back(2 + i);
      if (done) done_cnt++;
      if (bif.ldst_valid || bif.mv_valid || (bif.eu_valid != 8'h00)) valid_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [15:0] l);
    prog_base = b; prog_len = l; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (bif.imem_rd !== 1'b0) begin errors++; $display("FAIL reset_imem_rd got %b exp 0", bif.imem_rd); end
    checks++; if (bif.imem_addr !== 12'h000) begin errors++; $display("FAIL reset_imem_addr got %h exp 000", bif.imem_addr); end
    checks++; if (bif.cmd_inst !== 32'h0) begin errors++; $display("FAIL reset_cmd_inst got %h exp 0", bif.cmd_inst); end
    checks++; if ({bif.ldst_valid, bif.mv_valid, bif.eu_valid} !== 10'h0) begin
      errors++; $display("FAIL reset_valids got %b exp 0", {bif.ldst_valid, bif.mv_valid, bif.eu_valid}); end
    checks++; if ({perf_cycles, perf_stalls} !== 64'h0) begin
      errors++; $display("FAIL reset_perf got %h/%h exp 0/0", perf_cycles, perf_stalls); end
    rst = 1'b0;
    cyc();
  endtask

  // load, move, store from 0x10 with memory latency 2; start mid-run is ignored
  task automatic test_sequence();
    int a0, h0, d0; logic seen; int exp_hs[3];
    exp_hs = '{0, 1, 0};
    mem_lat = 2; done_dly = 4;
    mem[12'h010] = 32'h0000_0001; mem[12'h011] = 32'h8000_0002; mem[12'h012] = 32'h4000_0003;
    a0 = addr_log.size(); h0 = hs_log.size(); d0 = done_cnt;
    pulse_start(12'h010, 16'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy got %b exp 1", busy); end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (i == 2) begin prog_base = 12'h070; prog_len = 16'd5; start = 1'b1; end
      else start = 1'b0;
      if (done) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL seq_done_timeout got %b exp 1", seen); end
    cyc(); cyc(); cyc();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL seq_done_pulses got %0d exp 1", done_cnt - d0); end
    checks++; if (addr_log.size() - a0 !== 3) begin errors++; $display("FAIL seq_fetch_count got %0d exp 3", addr_log.size() - a0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_log[a0 + i] !== 12'(12'h010 + i)) begin
        errors++; $display("FAIL seq_addr%0d got %h exp %h", i, addr_log[a0 + i], 12'(12'h010 + i)); end
    end
    checks++; if (hs_log.size() - h0 !== 3) begin errors++; $display("FAIL seq_hs_count got %0d exp 3", hs_log.size() - h0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hs_log[h0 + i] !== exp_hs[i]) begin
        errors++; $display("FAIL seq_hs%0d got %0d exp %0d", i, hs_log[h0 + i], exp_hs[i]); end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL seq_err got %b exp 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seq_busy_end got %b exp 0", busy); end
    checks++; if (bif.cmd_inst !== 32'h4000_0003) begin errors++; $display("FAIL seq_cmd_inst got %h exp 40000003", bif.cmd_inst); end
  endtask

  // eu fetch then exec on unit 2, eu_busy[2] blocks the second issue for 5 cycles
  task automatic test_eu_stall();
    int h0; logic seen;
    mem_lat = 1;
    mem[12'h020] = 32'hC200_0000; mem[12'h021] = 32'hE200_0000;
    h0 = hs_log.size();
    pulse_start(12'h020, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bif.cmd_inst == 32'hE200_0000) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL eu_second_fetch_timeout got %b exp 1", seen); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (bif.eu_valid !== 8'h00) begin errors++; $display("FAIL eu_withheld_c%0d got %h exp 00", k, bif.eu_valid); end
      if (k == 0) bif.eu_busy = 8'h04;
      if (k == 5) bif.eu_busy = 8'h00;
      cyc();
    end
    checks++; if (bif.eu_valid !== 8'h04) begin errors++; $display("FAIL eu_valid_release got %h exp 04", bif.eu_valid); end
    bif.eu_busy = 8'h20;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL eu_drain_early_done_c%0d got %b exp 0", k, done); end
    end
    bif.eu_busy = 8'h00;
    cyc();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL eu_drain_done got %b exp 1", done); end
    checks++; if ((hs_log.size() - h0 !== 2) || (hs_log[h0] !== 4) || (hs_log[h0 + 1] !== 4)) begin
      errors++; $display("FAIL eu_handshakes got %0d entries exp 2 on unit 2", hs_log.size() - h0); end
`ifdef INST_DISPATCH_PERF_EN
    checks++; if (perf_stalls !== 32'd5) begin errors++; $display("FAIL eu_perf_stalls got %0d exp 5", perf_stalls); end
    checks++; if (perf_cycles !== 32'd16) begin errors++; $display("FAIL eu_perf_cycles got %0d exp 16", perf_cycles); end
`else
    checks++; if ({perf_cycles, perf_stalls} !== 64'h0) begin
      errors++; $display("FAIL eu_perf_off got %h/%h exp 0/0", perf_cycles, perf_stalls); end
`endif
    cyc();
  endtask

  // unit 9 with 8 units -> ERROR; then a good program clears err
  task automatic test_error();
    int v0, d0; logic seen;
    mem[12'h030] = 32'hC900_0000; mem[12'h040] = 32'h8000_0005;
    v0 = valid_cnt;
    pulse_start(12'h030, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin cyc(); if (err) begin seen = 1'b1; break; end end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL err_timeout got %b exp 1", seen); end
    cyc(); cyc();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b exp 0", busy); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL err_no_valid got %0d exp 0", valid_cnt - v0); end
    d0 = done_cnt;
    pulse_start(12'h040, 16'd1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin cyc(); if (done) begin seen = 1'b1; break; end end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL err_recover_done got %b exp 1", seen); end
    cyc();
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL err_recover_pulses got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_zero_len();
    int r0;
    r0 = rd_cnt;
    pulse_start(12'h123, 16'd0);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL zero_c1 busy/done got %b exp 10", {busy, done}); end
    cyc();
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL zero_c2 busy/done got %b exp 01", {busy, done}); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_c3 done got %b exp 0", done); end
    checks++; if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL zero_no_fetch got %0d exp 0", rd_cnt - r0); end
  endtask

  task automatic test_wrap();
    int a0; logic seen;
    done_dly = 2;
    mem[12'hFFF] = 32'h0000_0007; mem[12'h000] = 32'h8000_0008;
    a0 = addr_log.size();
    pulse_start(12'hFFF, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin cyc(); if (done) begin seen = 1'b1; break; end end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", seen); end
    checks++; if (addr_log.size() - a0 !== 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", addr_log.size() - a0); end
    checks++; if (addr_log[a0] !== 12'hFFF) begin errors++; $display("FAIL wrap_addr0 got %h exp FFF", addr_log[a0]); end
    checks++; if (addr_log[a0 + 1] !== 12'h000) begin errors++; $display("FAIL wrap_addr1 got %h exp 000", addr_log[a0 + 1]); end
    cyc();
  endtask

  task automatic test_abort_and_reset();
    int h0, d0; logic seen;
    done_dly = 6;
    mem[12'h050] = 32'h0000_0009; mem[12'h060] = 32'h0000_000A;
    h0 = hs_log.size(); d0 = done_cnt;
    pulse_start(12'h050, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin cyc(); if (hs_log.size() > h0) begin seen = 1'b1; break; end end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_hs_timeout got %b exp 1", seen); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++; if ({busy, bif.imem_rd, bif.ldst_valid, bif.mv_valid, bif.eu_valid} !== 11'h0) begin
      errors++; $display("FAIL abort_idle got %b exp 0", {busy, bif.imem_rd, bif.ldst_valid, bif.mv_valid, bif.eu_valid}); end
    for (int i = 0; i < 10; i++) cyc();
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_late_done got busy %b exp 0", busy); end

    mem_lat = 4;
    pulse_start(12'h060, 16'd1);
    cyc();
    rst = 1'b1;
    #1;
    checks++; if ({busy, bif.imem_addr, bif.cmd_inst} !== 45'h0) begin
      errors++; $display("FAIL rst_async got busy %b addr %h inst %h exp 0", busy, bif.imem_addr, bif.cmd_inst); end
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    checks++; if (bif.cmd_inst !== 32'h0) begin errors++; $display("FAIL rst_late_rvalid got %h exp 0", bif.cmd_inst); end
    checks++; if ({busy, done, bif.ldst_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_idle got %b exp 000", {busy, done, bif.ldst_valid}); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_no_done got %0d exp 0", done_cnt - d0); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_base = '0; prog_len = '0;
    bif.ldst_ready = 1'b1; bif.mv_ready = 1'b1;
    bif.eu_ready = 8'hFF;  bif.eu_busy = 8'h00;
    test_reset();
    test_sequence();
    test_eu_stall();
    test_error();
    test_zero_len();
    test_wrap();
    test_abort_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end
endmodule
